fp32_acc_buffer_dual: RTL and testbench

Dual-lane partial-sum buffer that sits directly downstream of the fp32_adder_dual pipeline and closes the accumulation loop.
- Holds one {exponent, mantissa} partial sum per output address for lane 0 and lane 1.
- On request, reads the stored sums and drives them into the adder's acc operands, together with bias_mode.
- Writes the normalized adder results back to the same address after the adder latency.
- After a run drains, exposes a read-out port for the final sums.

---
 rtl/fp32_acc_buffer_dual.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fp32_acc_buffer_dual.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_acc_buffer_dual.sv
// fp32_acc_buffer_dual
// ---------------------------------------------------------------------------
// Dual-lane partial-sum buffer that closes the accumulation loop around the
// fp32_adder_dual pipeline. Each of the two lanes keeps one {exponent,
// mantissa} partial sum per address.
//   * An accepted request reads the stored sums, or zeros on a first pass,
//     and drives them to the adder one cycle later together with bias_mode.
//   * The adder result is written back to the same address
//     ADDER_LATENCY+1 cycles after the request.
//   * Once a run has drained, a read-out port exposes the final sums.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start, finish             run control pulses
//   acc_req_valid/addr/first  accumulate request (accepted in ACCUM only)
//   bias_mode, *_acc_0/1      registered operands to the adder
//   exponent/mantissa_*_in    normalized adder results (write-back data)
//   busy, done                state is ACCUM/DRAIN, state is DONE
//   out_rd_en/addr            read-out request (IDLE or DONE only)
//   out_rd_valid, out_rd_*    read-out data, one cycle after out_rd_en
//   hazard_err                sticky: a request hit an in-flight write-back
//   dbg_state                 current FSM state
//
// Handshake: a request is a single-cycle acc_req_valid pulse. There is no
// ready signal. A request is taken if and only if the state is ACCUM in that
// cycle; in any other state it is dropped silently. out_rd_en follows the
// same rule, but applies in IDLE or DONE.
//
// Optional feature macro: FP_ACC_HAZARD_CHECK_EN. When it is defined, the
// address comparators against the write-back delay line are built. When it
// is undefined, hazard_err is tied to 0.
// ---------------------------------------------------------------------------
module fp32_acc_buffer_dual #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISA_WIDTH  = 24,
    parameter int DEPTH          = 64,
    parameter int ADDR_WIDTH     = 6,
    parameter int ADDER_LATENCY  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      finish,
    input  logic                      acc_req_valid,
    input  logic [ADDR_WIDTH-1:0]     acc_req_addr,
    input  logic                      acc_req_first,
    output logic                      bias_mode,
    output logic [EXPONENT_WIDTH-1:0] exponent_acc_0,
    output logic [EXPONENT_WIDTH-1:0] exponent_acc_1,
    output logic [MANTISA_WIDTH-1:0]  mantissa_acc_0,
    output logic [MANTISA_WIDTH-1:0]  mantissa_acc_1,
    input  logic [EXPONENT_WIDTH-1:0] exponent_0_in,
    input  logic [EXPONENT_WIDTH-1:0] exponent_1_in,
    input  logic [MANTISA_WIDTH-1:0]  mantissa_0_in,
    input  logic [MANTISA_WIDTH-1:0]  mantissa_1_in,
    output logic                      busy,
    output logic                      done,
    input  logic                      out_rd_en,
    input  logic [ADDR_WIDTH-1:0]     out_rd_addr,
    output logic                      out_rd_valid,
    output logic [EXPONENT_WIDTH-1:0] out_rd_exponent_0,
    output logic [EXPONENT_WIDTH-1:0] out_rd_exponent_1,
    output logic [MANTISA_WIDTH-1:0]  out_rd_mantissa_0,
    output logic [MANTISA_WIDTH-1:0]  out_rd_mantissa_1,
    output logic                      hazard_err,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Stage k holds the request issued k+1 cycles ago. The last stage is
    // the one whose adder result is present on the *_in ports this cycle.
    localparam int STAGES = ADDER_LATENCY + 1;

    logic [1:0]            state_q, state_d;
    logic [STAGES-1:0]     dl_valid_q, dl_valid_d;
    logic [ADDR_WIDTH-1:0] dl_addr_q [STAGES];
    logic [ADDR_WIDTH-1:0] dl_addr_d [STAGES];

    logic                      bias_q, bias_d;
    logic [EXPONENT_WIDTH-1:0] exp_acc_0_q, exp_acc_0_d, exp_acc_1_q, exp_acc_1_d;
    logic [MANTISA_WIDTH-1:0]  man_acc_0_q, man_acc_0_d, man_acc_1_q, man_acc_1_d;

    logic                      rd_valid_q, rd_valid_d;
    logic [EXPONENT_WIDTH-1:0] rd_exp_0_q, rd_exp_0_d, rd_exp_1_q, rd_exp_1_d;
    logic [MANTISA_WIDTH-1:0]  rd_man_0_q, rd_man_0_d, rd_man_1_q, rd_man_1_d;

    logic hazard_q, hazard_d;

    // Partial-sum storage. These arrays are deliberately not reset.
    logic [EXPONENT_WIDTH-1:0] mem_exp_0 [DEPTH];
    logic [EXPONENT_WIDTH-1:0] mem_exp_1 [DEPTH];
    logic [MANTISA_WIDTH-1:0]  mem_man_0 [DEPTH];
    logic [MANTISA_WIDTH-1:0]  mem_man_1 [DEPTH];

    logic                  idle_or_done;
    logic                  start_accept;
    logic                  req_accept;
    logic                  rd_accept;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  addr_hit;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_accept = idle_or_done && start;
    assign req_accept   = (state_q == ST_ACCUM) && acc_req_valid;
    assign rd_accept    = idle_or_done && out_rd_en;
    assign wr_en        = dl_valid_q[STAGES-1];
    assign wr_addr      = dl_addr_q[STAGES-1];

`ifdef FP_ACC_HAZARD_CHECK_EN
    // A request collides with any write-back still in flight. This includes
    // the write that lands in this same cycle, because that read returns the
    // old data.
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (dl_valid_q[i] && (dl_addr_q[i] == acc_req_addr)) begin
                addr_hit = 1'b1;
            end
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    // FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ACCUM;
            ST_ACCUM: if (finish) state_d = ST_DRAIN;
            // Stages 0..STAGES-2 are empty, so the only write left, if any,
            // lands on this edge. The memory is therefore final from the
            // next cycle onward.
            ST_DRAIN: if (~|dl_valid_q[STAGES-2:0]) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write-back delay line
    always_comb begin
        dl_valid_d   = {dl_valid_q[STAGES-2:0], req_accept};
        dl_addr_d[0] = acc_req_addr;
        for (int i = 1; i < STAGES; i++) begin
            dl_addr_d[i] = dl_addr_q[i-1];
        end
    end

    // Adder operand path. The memory is read before this edge's write-back,
    // so a same-address collision returns the old sum.
    always_comb begin
        bias_d      = req_accept && acc_req_first;
        exp_acc_0_d = '0;
        exp_acc_1_d = '0;
        man_acc_0_d = '0;
        man_acc_1_d = '0;
        if (req_accept && !acc_req_first) begin
            exp_acc_0_d = mem_exp_0[acc_req_addr];
            exp_acc_1_d = mem_exp_1[acc_req_addr];
            man_acc_0_d = mem_man_0[acc_req_addr];
            man_acc_1_d = mem_man_1[acc_req_addr];
        end
    end

    // Read-out path
    always_comb begin
        rd_valid_d = rd_accept;
        rd_exp_0_d = '0;
        rd_exp_1_d = '0;
        rd_man_0_d = '0;
        rd_man_1_d = '0;
        if (rd_accept) begin
            rd_exp_0_d = mem_exp_0[out_rd_addr];
            rd_exp_1_d = mem_exp_1[out_rd_addr];
            rd_man_0_d = mem_man_0[out_rd_addr];
            rd_man_1_d = mem_man_1[out_rd_addr];
        end
    end

    // Sticky hazard flag. An accepted start clears it. Requests are only
    // accepted in ACCUM, so the clear and the set can never coincide.
    always_comb begin
        hazard_d = hazard_q;
        if (start_accept) begin
            hazard_d = 1'b0;
        end else if (req_accept && addr_hit) begin
            hazard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dl_valid_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dl_addr_q[i] <= '0;
            end
            bias_q      <= 1'b0;
            exp_acc_0_q <= '0;
            exp_acc_1_q <= '0;
            man_acc_0_q <= '0;
            man_acc_1_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_exp_0_q  <= '0;
            rd_exp_1_q  <= '0;
            rd_man_0_q  <= '0;
            rd_man_1_q  <= '0;
            hazard_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_valid_q  <= dl_valid_d;
            for (int i = 0; i < STAGES; i++) begin
                dl_addr_q[i] <= dl_addr_d[i];
            end
            bias_q      <= bias_d;
            exp_acc_0_q <= exp_acc_0_d;
            exp_acc_1_q <= exp_acc_1_d;
            man_acc_0_q <= man_acc_0_d;
            man_acc_1_q <= man_acc_1_d;
            rd_valid_q  <= rd_valid_d;
            rd_exp_0_q  <= rd_exp_0_d;
            rd_exp_1_q  <= rd_exp_1_d;
            rd_man_0_q  <= rd_man_0_d;
            rd_man_1_q  <= rd_man_1_d;
            hazard_q    <= hazard_d;
        end
    end

    // Write-back into both lanes. Reset clears the delay line, so any
    // in-flight results are discarded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_exp_0[wr_addr] <= exponent_0_in;
            mem_exp_1[wr_addr] <= exponent_1_in;
            mem_man_0[wr_addr] <= mantissa_0_in;
            mem_man_1[wr_addr] <= mantissa_1_in;
        end
    end

    assign bias_mode         = bias_q;
    assign exponent_acc_0    = exp_acc_0_q;
    assign exponent_acc_1    = exp_acc_1_q;
    assign mantissa_acc_0    = man_acc_0_q;
    assign mantissa_acc_1    = man_acc_1_q;
    assign out_rd_valid      = rd_valid_q;
    assign out_rd_exponent_0 = rd_exp_0_q;
    assign out_rd_exponent_1 = rd_exp_1_q;
    assign out_rd_mantissa_0 = rd_man_0_q;
    assign out_rd_mantissa_1 = rd_man_1_q;
    assign hazard_err        = hazard_q;
    assign busy              = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign done              = (state_q == ST_DONE);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fp32_acc_buffer_dual.sv
// Bench for fp32_acc_buffer_dual. It runs directed run scenarios followed
// by a randomized run. The reference model works at the level of whole
// runs: run phases, one array of sums per lane, and a list of pending
// write-backs with due cycles.
module tb_fp32_acc_buffer_dual;
  localparam int EW    = 8;
  localparam int MW    = 24;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LAT   = 4;
`ifdef FP_ACC_HAZARD_CHECK_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start, finish, acc_req_valid, acc_req_first, out_rd_en;
  logic [AW-1:0] acc_req_addr, out_rd_addr;
  logic          bias_mode, busy, done, out_rd_valid, hazard_err;
  logic [EW-1:0] exponent_acc_0, exponent_acc_1, exponent_0_in, exponent_1_in;
  logic [MW-1:0] mantissa_acc_0, mantissa_acc_1, mantissa_0_in, mantissa_1_in;
  logic [EW-1:0] out_rd_exponent_0, out_rd_exponent_1;
  logic [MW-1:0] out_rd_mantissa_0, out_rd_mantissa_1;
  logic [1:0]    dbg_state;

  fp32_acc_buffer_dual #(
    .EXPONENT_WIDTH(EW), .MANTISA_WIDTH(MW), .DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .ADDER_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .acc_req_valid(acc_req_valid), .acc_req_addr(acc_req_addr),
    .acc_req_first(acc_req_first), .bias_mode(bias_mode),
    .exponent_acc_0(exponent_acc_0), .exponent_acc_1(exponent_acc_1),
    .mantissa_acc_0(mantissa_acc_0), .mantissa_acc_1(mantissa_acc_1),
    .exponent_0_in(exponent_0_in), .exponent_1_in(exponent_1_in),
    .mantissa_0_in(mantissa_0_in), .mantissa_1_in(mantissa_1_in),
    .busy(busy), .done(done), .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr),
    .out_rd_valid(out_rd_valid),
    .out_rd_exponent_0(out_rd_exponent_0), .out_rd_exponent_1(out_rd_exponent_1),
    .out_rd_mantissa_0(out_rd_mantissa_0), .out_rd_mantissa_1(out_rd_mantissa_1),
    .hazard_err(hazard_err), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // Run phase: 0 idle, 1 accumulating, 2 draining, 3 done.
  int            m_phase;
  logic [EW-1:0] m_e0 [DEPTH];
  logic [EW-1:0] m_e1 [DEPTH];
  logic [MW-1:0] m_m0 [DEPTH];
  logic [MW-1:0] m_m1 [DEPTH];
  bit            m_known [DEPTH];
  int            pend_addr[$];
  int            pend_due[$];
  bit            m_hazard;
  int            cyc;
  logic [63:0]   exp_q[$];

  bit            fixed_res;
  logic [EW-1:0] fix_e;
  logic [MW-1:0] fix_m;

  int n_vec;
  int n_err;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, advance the model, then compare every
  // registered output once the edge has passed.
  task automatic cycle(input bit req_v, input int addr, input bit first,
                       input bit fin, input bit st, input bit rd_en, input int rd_addr);
    bit          acc_ok, use_mem, rd_ok, hit, acc_chk;
    logic [63:0] e_acc;
    int          a;
    @(negedge clk);
    start         = st;
    finish        = fin;
    acc_req_valid = req_v;
    acc_req_addr  = AW'(addr);
    acc_req_first = first;
    out_rd_en     = rd_en;
    out_rd_addr   = AW'(rd_addr);
    if (fixed_res) begin
      exponent_0_in = fix_e; exponent_1_in = fix_e;
      mantissa_0_in = fix_m; mantissa_1_in = fix_m;
    end else begin
      exponent_0_in = EW'($urandom_range(255, 0));
      exponent_1_in = EW'($urandom_range(255, 0));
      mantissa_0_in = MW'($urandom);
      mantissa_1_in = MW'($urandom);
    end

    acc_ok  = (m_phase == 1) && req_v;
    use_mem = acc_ok && !first;
    acc_chk = !use_mem || m_known[addr];
    e_acc   = use_mem ? {m_e0[addr], m_m0[addr], m_e1[addr], m_m1[addr]} : 64'd0;
    hit = 1'b0;
    foreach (pend_addr[i]) if (pend_addr[i] == addr) hit = 1'b1;
    rd_ok = rd_en && (m_phase == 0 || m_phase == 3) && m_known[rd_addr];
    if (rd_ok) exp_q.push_back({m_e0[rd_addr], m_m0[rd_addr], m_e1[rd_addr], m_m1[rd_addr]});
    rd_ok = rd_en && (m_phase == 0 || m_phase == 3);

    // Results of the request issued LAT+1 cycles ago land now (after the read).
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      m_e0[a] = exponent_0_in; m_e1[a] = exponent_1_in;
      m_m0[a] = mantissa_0_in; m_m1[a] = mantissa_1_in;
      m_known[a] = 1'b1;
    end
    if (acc_ok) begin
      pend_addr.push_back(addr);
      pend_due.push_back(cyc + LAT + 1);
    end
    if ((m_phase == 0 || m_phase == 3) && st) m_hazard = 1'b0;
    else if (acc_ok && hit && HAZ_EN) m_hazard = 1'b1;
    case (m_phase)
      0, 3: if (st) m_phase = 1;
      1:    if (fin) m_phase = 2;
      2:    if (pend_addr.size() == 0) m_phase = 3;
      default: m_phase = 0;
    endcase

    @(posedge clk);
    #1;
    check("bias_mode", 64'(bias_mode), 64'(acc_ok && first));
    if (acc_chk)
      check("acc_ops", {exponent_acc_0, mantissa_acc_0, exponent_acc_1, mantissa_acc_1}, e_acc);
    check("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
    check("done", 64'(done), 64'(m_phase == 3));
    check("hazard_err", 64'(hazard_err), 64'(m_hazard));
    check("rd_valid", 64'(out_rd_valid), 64'(rd_ok));
    if (rd_ok && m_known[rd_addr] && exp_q.size() > 0)
      check("rd_data", {out_rd_exponent_0, out_rd_mantissa_0, out_rd_exponent_1, out_rd_mantissa_1},
            exp_q.pop_front());
    cyc++;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      idle_cycle();
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0; finish = 1'b0; acc_req_valid = 1'b0; out_rd_en = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bias", 64'(bias_mode), 64'd0);
    check("rst_acc", {exponent_acc_0, mantissa_acc_0, exponent_acc_1, mantissa_acc_1}, 64'd0);
    check("rst_rdv", 64'(out_rd_valid), 64'd0);
    check("rst_hazard", 64'(hazard_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    m_phase  = 0;
    m_hazard = 1'b0;
    cyc += 2;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    n_vec = 0; n_err = 0; cyc = 0;
    m_phase = 0; m_hazard = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    rst = 1'b1;
    start = 1'b0; finish = 1'b0; acc_req_valid = 1'b0; acc_req_addr = '0;
    acc_req_first = 1'b0; out_rd_en = 1'b0; out_rd_addr = '0;
    exponent_0_in = '0; exponent_1_in = '0; mantissa_0_in = '0; mantissa_1_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_reset();

    // First pass on addr 3, result 1.0.
    fixed_res = 1'b1; fix_e = 8'd127; fix_m = 24'h800000;
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 3, 1, 0, 0, 0, 0);
    check("t1_bias", 64'(bias_mode), 64'd1);
    check("t1_acc_zero", {exponent_acc_0, mantissa_acc_0, exponent_acc_1, mantissa_acc_1}, 64'd0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    wait_done(20, n);
    cycle(0, 0, 0, 0, 0, 1, 3);
    check("t1_rd", {out_rd_exponent_0, out_rd_mantissa_0, out_rd_exponent_1, out_rd_mantissa_1},
          {8'd127, 24'h800000, 8'd127, 24'h800000});

    // Second pass on addr 3, reads back 1.0, result 2.0.
    fix_e = 8'd128;
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 3, 0, 0, 0, 0, 0);
    check("t2_acc", {exponent_acc_0, mantissa_acc_0, exponent_acc_1, mantissa_acc_1},
          {8'd127, 24'h800000, 8'd127, 24'h800000});
    cycle(0, 0, 0, 1, 0, 0, 0);
    wait_done(20, n);
    cycle(0, 0, 0, 0, 0, 1, 3);
    check("t2_rd", {out_rd_exponent_0, out_rd_mantissa_0, out_rd_exponent_1, out_rd_mantissa_1},
          {8'd128, 24'h800000, 8'd128, 24'h800000});
    fixed_res = 1'b0;

    // Back-to-back requests to addr 5.
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0);
    cycle(1, 5, 0, 0, 0, 0, 0);
    check("t3_hazard_set", 64'(hazard_err), 64'(HAZ_EN));
    repeat (3) idle_cycle();
    check("t3_hazard_sticky", 64'(hazard_err), 64'(HAZ_EN));
    cycle(0, 0, 0, 1, 0, 0, 0);
    wait_done(20, n);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("t3_hazard_clr", 64'(hazard_err), 64'd0);

    // finish together with a request to addr 7.
    cycle(1, 7, 1, 1, 0, 0, 0);
    check("t4_busy", 64'(busy), 64'd1);
    wait_done(20, n);
    check("t4_drain_len", 64'(n), 64'(LAT + 1));
    cycle(0, 0, 0, 0, 0, 1, 7);

    // Read-out is ignored while busy, served once done.
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("t5_rdv_accum", 64'(out_rd_valid), 64'd0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    wait_done(20, n);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("t5_rdv_done", 64'(out_rd_valid), 64'd1);

    // Randomized run over a small address window to provoke collisions.
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 300; k++) begin
      cycle($urandom_range(99, 0) < 60, int'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
            1'b0, $urandom_range(99, 0) < 5, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    wait_done(20, n);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0, 0, 1, k);

    // Reset while draining with two write-backs still in flight.
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 3, 1, 0, 0, 0, 0);
    cycle(1, 7, 1, 1, 0, 0, 0);
    idle_cycle();
    do_reset();
    cycle(0, 0, 0, 0, 0, 1, 3);
    cycle(0, 0, 0, 0, 0, 1, 7);
    repeat (LAT + 2) idle_cycle();
    cycle(0, 0, 0, 0, 0, 1, 7);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("t6_restart", 64'(busy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
